via_sr_peer: RTL and testbench

//   Serial peer for the via6522 shift register: the device on the far end of CB1/CB2.

---
 rtl/via_sr_peer.sv | 160 ++++++++++++++++
 tb/tb_via_sr_peer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/via_sr_peer.sv
// Far-end serial peer for the via6522 shift register on CB1/CB2.
// Acts as a CB1 slave (VIA clocks) or as the CB1 master (VIA external-clock modes).
module via_sr_peer #(
    parameter int unsigned HALF_PERIOD = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       master,
    input  logic       start,
    input  logic       clear,
    input  logic [7:0] tx_data,
    input  logic       tx_load,
    output logic       tx_full,
    output logic       busy,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       cb1_in,
    output logic       cb1_out,
    input  logic       cb2_in,
    output logic       cb2_out
);

    localparam int unsigned CW = (HALF_PERIOD > 2) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [CW-1:0] HP_LAST = CW'(HALF_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          cb1_s1, cb1_s2, cb1_d, cb2_s1, cb2_s2;
    logic [7:0]    tx_sr, rx_sr, hold;
    logic [2:0]    bit_cnt;
    logic          mode_r;
    logic          idle, mode, rise, fall, s_rise, s_fall;
    logic          m_start, m_bit, shift, byte_done;

    assign idle      = (state == IDLE) && (bit_cnt == '0);
    // The master input is only honoured between bytes; mid-byte the latched mode holds.
    assign mode      = idle ? master : mode_r;
    assign rise      = cb1_s2 & ~cb1_d;
    assign fall      = ~cb1_s2 & cb1_d;
    assign s_rise    = rise & ~mode & ~clear;
    assign s_fall    = fall & ~mode & ~clear;
    assign shift     = s_rise | m_bit;
    assign byte_done = shift & (bit_cnt == 3'd7);
    assign busy      = ~idle;
    assign cb1_out   = (state != LOW);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        m_start  = 1'b0;
        m_bit    = 1'b0;
        case (state)
            IDLE: begin
                if (start && master && bit_cnt == '0) begin
                    state_nx = LOW;
                    cnt_nx   = HP_LAST;
                    m_start  = 1'b1;
                end
            end
            LOW: begin
                if (cnt == '0) begin
                    state_nx = HIGH;
                    cnt_nx   = HP_LAST;
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            HIGH: begin
                if (cnt == '0) begin
                    m_bit    = 1'b1;
                    cnt_nx   = HP_LAST;
                    state_nx = (bit_cnt == 3'd7) ? IDLE : LOW;
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
        if (clear) begin
            state_nx = IDLE;
            m_start  = 1'b0;
            m_bit    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cb1_s1   <= 1'b1;
            cb1_s2   <= 1'b1;
            cb1_d    <= 1'b1;
            cb2_s1   <= 1'b1;
            cb2_s2   <= 1'b1;
            cb2_out  <= 1'b1;
            tx_sr    <= '1;
            rx_sr    <= '0;
            hold     <= '0;
            tx_full  <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            bit_cnt  <= '0;
            mode_r   <= 1'b0;
        end else begin
            cb1_s1   <= cb1_in;
            cb1_s2   <= cb1_s1;
            cb1_d    <= cb1_s2;
            cb2_s1   <= cb2_in;
            cb2_s2   <= cb2_s1;
            mode_r   <= mode;
            rx_valid <= 1'b0;

            if (clear)
                bit_cnt <= '0;
            else if (shift)
                bit_cnt <= bit_cnt + 3'd1;

            if (shift) begin
                rx_sr <= {rx_sr[6:0], cb2_s2};
                tx_sr <= {tx_sr[6:0], 1'b1};
            end

            if (byte_done) begin
                rx_data  <= {rx_sr[6:0], cb2_s2};
                rx_valid <= 1'b1;
                tx_sr    <= tx_full ? hold : '1;
                tx_full  <= 1'b0;
            end

            // Entering LOW after a master bit presents the post-shift MSB, i.e. tx_sr[6].
            if (s_fall || m_start)
                cb2_out <= tx_sr[7];
            else if (m_bit && bit_cnt != 3'd7)
                cb2_out <= tx_sr[6];

            // A load coinciding with byte end lands in tx_sr, after the reload above.
            if (tx_load) begin
                if (idle || byte_done) begin
                    tx_sr <= tx_data;
                    if (idle)
                        cb2_out <= tx_data[7];
                end else begin
                    hold    <= tx_data;
                    tx_full <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_via_sr_peer.sv
// Directed bench for via_sr_peer: slave rx/tx, master loopback, buffering, clear, reset.
module tb_via_sr_peer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       master = 1'b0, start = 1'b0, clear = 1'b0, tx_load = 1'b0;
    logic [7:0] tx_data = '0;
    logic       cb1_in = 1'b1, cb2_drv = 1'b1, loop = 1'b0;
    logic       tx_full, busy, rx_valid, cb1_out, cb2_out, cb2_in;
    logic [7:0] rx_data;

    int  n_chk = 0, n_pass = 0;
    int  rxv_cnt = 0, fall_cnt = 0;
    time fall_last = 0, fall_per = 0;
    logic cb1_prev = 1'b1;

    assign cb2_in = loop ? cb2_out : cb2_drv;

    via_sr_peer #(.HALF_PERIOD(4)) dut (
        .clk(clk), .reset(reset), .master(master), .start(start), .clear(clear),
        .tx_data(tx_data), .tx_load(tx_load), .tx_full(tx_full), .busy(busy),
        .rx_data(rx_data), .rx_valid(rx_valid), .cb1_in(cb1_in), .cb1_out(cb1_out),
        .cb2_in(cb2_in), .cb2_out(cb2_out)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid === 1'b1) rxv_cnt++;
        if (cb1_prev === 1'b1 && cb1_out === 1'b0) begin
            fall_cnt++;
            fall_per  = $time - fall_last;
            fall_last = $time;
        end
        cb1_prev = cb1_out;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic slave_pulse(input logic b, output logic seen);
        cb1_in  = 1'b0;
        cb2_drv = b;
        tick(5);
        seen   = cb2_out;
        cb1_in = 1'b1;
        tick(5);
    endtask

    // v4 = rx_valid pulses seen within 4 clk of the 8th rise
    task automatic slave_byte(input logic [7:0] b, output logic [7:0] seen, output int v4);
        int base;
        base = rxv_cnt;
        v4   = 0;
        for (int i = 7; i >= 0; i--) begin
            cb1_in  = 1'b0;
            cb2_drv = b[i];
            tick(5);
            seen[i] = cb2_out;
            cb1_in  = 1'b1;
            tick(4);
            v4 = rxv_cnt - base;
            tick(1);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic load(input logic [7:0] d);
        tx_data = d;
        tx_load = 1'b1;
        tick(1);
        tx_load = 1'b0;
    endtask

    initial begin
        logic [7:0] seen;
        logic       bit_seen;
        int         v4, base_rx, base_fall;

        #1 reset = 1'b0;
        #3;
        chk("rst_cb1_out", cb1_out, 1);
        chk("rst_cb2_out", cb2_out, 1);
        chk("rst_busy", busy, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_tx_full", tx_full, 0);
        tick(2);
        reset = 1'b1;
        tick(3);

        // slave receive E7; transmit side idles at FF
        base_rx = rxv_cnt;
        slave_byte(8'hE7, seen, v4);
        chk("srx_data", rx_data, 8'hE7);
        chk("srx_valid_4clk", v4, 1);
        chk("srx_tx_ff", seen, 8'hFF);
        tick(3);
        chk("srx_valid_once", rxv_cnt - base_rx, 1);
        chk("srx_busy", busy, 0);

        // slave transmit C5, then FF with no reload
        load(8'hC5);
        chk("stx_cb2_first", cb2_out, 1);
        slave_byte(8'h00, seen, v4);
        chk("stx_c5", seen, 8'hC5);
        chk("stx_rx_00", rx_data, 8'h00);
        slave_byte(8'h5A, seen, v4);
        chk("stx_ff", seen, 8'hFF);
        chk("stx_rx_5a", rx_data, 8'h5A);

        // master loopback 3E
        master = 1'b1;
        loop   = 1'b1;
        tick(2);
        load(8'h3E);
        base_fall = fall_cnt;
        base_rx   = rxv_cnt;
        pulse_start();
        chk("m_busy_start", busy, 1);
        tick(63);
        chk("m_busy_63", busy, 1);
        tick(1);
        chk("m_busy_64", busy, 0);
        tick(1);
        chk("m_pulses", fall_cnt - base_fall, 8);
        chk("m_period", 32'(fall_per), 80);
        chk("m_rx_3e", rx_data, 8'h3E);
        chk("m_rx_valid", rxv_cnt - base_rx, 1);

        // buffering: ignored start, mid-byte load into hold register
        base_fall = fall_cnt;
        pulse_start();
        tick(9);
        pulse_start();
        load(8'h81);
        chk("buf_tx_full", tx_full, 1);
        tick(53);
        chk("buf_busy_64", busy, 0);
        tick(1);
        chk("buf_pulses", fall_cnt - base_fall, 8);
        chk("buf_rx_ff", rx_data, 8'hFF);
        chk("buf_tx_full_clr", tx_full, 0);
        pulse_start();
        tick(65);
        chk("buf_rx_81", rx_data, 8'h81);
        chk("buf_busy_end", busy, 0);

        // clear after 3 slave rises
        master = 1'b0;
        loop   = 1'b0;
        tick(2);
        base_rx = rxv_cnt;
        for (int i = 0; i < 3; i++) slave_pulse(1'b1, bit_seen);
        chk("clr_busy_before", busy, 1);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        chk("clr_busy_after", busy, 0);
        tick(4);
        chk("clr_no_valid", rxv_cnt - base_rx, 0);
        slave_byte(8'hA5, seen, v4);
        chk("clr_rx_a5", rx_data, 8'hA5);

        // asynchronous reset mid master byte
        master = 1'b1;
        loop   = 1'b1;
        tick(2);
        load(8'h00);
        chk("ar_cb2_loaded", cb2_out, 0);
        pulse_start();
        tick(17);
        chk("ar_busy_mid", busy, 1);
        chk("ar_cb1_low", cb1_out, 0);
        #2 reset = 1'b0;
        #1;
        chk("ar_cb1_out", cb1_out, 1);
        chk("ar_cb2_out", cb2_out, 1);
        chk("ar_busy", busy, 0);
        chk("ar_rx_data", rx_data, 8'h00);
        tick(1);
        reset = 1'b1;
        base_fall = fall_cnt;
        tick(20);
        chk("ar_idle_no_pulses", fall_cnt - base_fall, 0);
        chk("ar_idle_busy", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
